// File: rtl/corelet_seq_pkg.sv
// Shared definitions for the corelet job sequencer: state codes, instruction
// encodings and a small elaboration-time helper.
package corelet_seq_pkg;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_EXEC  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_NEXT  = 3'd4;
  localparam logic [2:0] S_FIN   = 3'd5;

  localparam logic [1:0] INST_IDLE = 2'b00;
  localparam logic [1:0] INST_LOAD = 2'b01;
  localparam logic [1:0] INST_EXEC = 2'b10;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/corelet_seq_counter.sv
// Up-counter with clear-to-zero load, count enable and a terminal-count flag
// raised while the count equals the supplied terminal value.
module seq_counter #(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic [width-1:0] term,
  output logic [width-1:0] cnt,
  output logic             tc
);

  logic [width-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + width'(1);
    end
  end

  assign cnt = cnt_q;
  assign tc  = (cnt_q == term);

endmodule

// File: rtl/corelet_seq.sv
// Corelet job sequencer: walks kernel load, execute and drain phases for each
// accumulation pass and drives the corelet control strobes directly.
module corelet_seq
  import corelet_seq_pkg::*;
#(
  parameter int row = 8,
  parameter int col = 8,
  parameter int cw  = 10,
  parameter int tmo = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          mode_cfg,
  input  logic          relu_cfg,
  input  logic [cw-1:0] n_vec,
  input  logic [3:0]    n_pass,
  input  logic          ofifo_valid,
  output logic [1:0]    inst,
  output logic          l0_rd,
  output logic          ififo_rd,
  output logic          ofifo_rd,
  output logic          mode,
  output logic          acc,
  output logic          relu,
  output logic          psum_we,
  output logic [cw-1:0] psum_addr,
  output logic          os_capture,
  output logic          busy,
  output logic          done,
  output logic          error
);

  // Phase counter must reach both n_vec-1 and the OS flush length row+col-1.
  localparam int PW = max_int(cw, $clog2(row + col + 1));
  localparam int WW = max_int(1, $clog2(tmo + 1));

  logic [2:0]    state_q, state_d;
  logic          mode_q, mode_d;
  logic          relu_q, relu_d;
  logic [cw-1:0] n_vec_q, n_vec_d;
  logic [3:0]    n_pass_q, n_pass_d;
  logic [3:0]    pass_q, pass_d;
  logic          error_q, error_d;

  logic          state_chg;
  logic          ws_drain;
  logic          last_pass;
  logic          ph_en, ph_tc;
  logic [PW-1:0] ph_term;
  logic [PW-1:0] ph_cnt_unused;
  logic          addr_tc;
  logic [cw-1:0] addr_cnt;
  logic          wd_tc;
  logic [WW-1:0] wd_cnt_unused;

  assign state_chg = (state_d != state_q);
  assign ws_drain  = (state_q == S_DRAIN) && !mode_q;
  assign last_pass = (pass_q == n_pass_q - 4'd1);

  always_comb begin
    ph_term = PW'(row + col - 1);
    case (state_q)
      S_LOAD:  ph_term = PW'(row - 1);
      S_EXEC:  ph_term = PW'(n_vec_q - cw'(1));
      default: ph_term = PW'(row + col - 1);
    endcase
  end

  assign ph_en = (state_q == S_LOAD) || (state_q == S_EXEC) ||
                 ((state_q == S_DRAIN) && mode_q);

  seq_counter #(.width(PW)) u_phase_cnt (
    .clk   (clk),
    .rst_n (reset),
    .load  (state_chg),
    .en    (ph_en),
    .term  (ph_term),
    .cnt   (ph_cnt_unused),
    .tc    (ph_tc)
  );

  seq_counter #(.width(cw)) u_addr_cnt (
    .clk   (clk),
    .rst_n (reset),
    .load  (state_chg),
    .en    (psum_we),
    .term  (n_vec_q - cw'(1)),
    .cnt   (addr_cnt),
    .tc    (addr_tc)
  );

  // Counts consecutive empty-OFIFO cycles; any valid row restarts it.
  seq_counter #(.width(WW)) u_wd_cnt (
    .clk   (clk),
    .rst_n (reset),
    .load  (state_chg || ofifo_valid),
    .en    (ws_drain && !ofifo_valid),
    .term  (WW'(tmo - 1)),
    .cnt   (wd_cnt_unused),
    .tc    (wd_tc)
  );

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    relu_d   = relu_q;
    n_vec_d  = n_vec_q;
    n_pass_d = n_pass_q;
    pass_d   = pass_q;
    error_d  = error_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d   = mode_cfg;
          relu_d   = relu_cfg;
          n_vec_d  = n_vec;
          n_pass_d = n_pass;
          pass_d   = '0;
          if ((n_vec == '0) || (n_pass == '0)) begin
            error_d = 1'b1;
            state_d = S_FIN;
          end else begin
            error_d = 1'b0;
            state_d = mode_cfg ? S_EXEC : S_LOAD;
          end
        end
      end
      S_LOAD: if (ph_tc) state_d = S_EXEC;
      S_EXEC: if (ph_tc) state_d = S_DRAIN;
      S_DRAIN: begin
        if (mode_q) begin
          if (ph_tc) state_d = S_NEXT;
        end else if (wd_tc && !ofifo_valid) begin
          error_d = 1'b1;
          state_d = S_FIN;
        end else if (psum_we && addr_tc) begin
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        if (!last_pass) begin
          pass_d  = pass_q + 4'd1;
          state_d = mode_q ? S_EXEC : S_LOAD;
        end else begin
          state_d = S_FIN;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      mode_q   <= 1'b0;
      relu_q   <= 1'b0;
      n_vec_q  <= '0;
      n_pass_q <= '0;
      pass_q   <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      relu_q   <= relu_d;
      n_vec_q  <= n_vec_d;
      n_pass_q <= n_pass_d;
      pass_q   <= pass_d;
      error_q  <= error_d;
    end
  end

  assign inst = (state_q == S_LOAD) ? INST_LOAD :
                ((state_q == S_EXEC) || (state_q == S_DRAIN)) ? INST_EXEC : INST_IDLE;

  assign l0_rd      = (state_q == S_LOAD) || (state_q == S_EXEC);
  assign ififo_rd   = (state_q == S_EXEC) && mode_q;
  assign psum_we    = ws_drain && ofifo_valid;
  assign ofifo_rd   = psum_we;
  assign acc        = psum_we && (pass_q != 4'd0);
  assign relu       = psum_we && relu_q && last_pass;
  assign psum_addr  = addr_cnt;
  assign os_capture = (state_q == S_NEXT) && mode_q;
  assign mode       = mode_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_FIN);
  assign error      = error_q;

endmodule

// File: tb/tb_corelet_seq.sv
// Randomised bench for corelet_seq: a loop-structured job model sets the
// expected strobes each cycle and a negedge process compares them.
module tb_corelet_seq;

  localparam int ROW = 8;
  localparam int COL = 8;
  localparam int CW  = 10;
  localparam int TMO = 255;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          mode_cfg = 1'b0;
  logic          relu_cfg = 1'b0;
  logic [CW-1:0] n_vec = '0;
  logic [3:0]    n_pass = '0;
  logic          ofifo_valid = 1'b0;
  logic [1:0]    inst;
  logic          l0_rd, ififo_rd, ofifo_rd, mode, acc, relu, psum_we;
  logic [CW-1:0] psum_addr;
  logic          os_capture, busy, done, error;

  corelet_seq #(.row(ROW), .col(COL), .cw(CW), .tmo(TMO)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .mode_cfg    (mode_cfg),
    .relu_cfg    (relu_cfg),
    .n_vec       (n_vec),
    .n_pass      (n_pass),
    .ofifo_valid (ofifo_valid),
    .inst        (inst),
    .l0_rd       (l0_rd),
    .ififo_rd    (ififo_rd),
    .ofifo_rd    (ofifo_rd),
    .mode        (mode),
    .acc         (acc),
    .relu        (relu),
    .psum_we     (psum_we),
    .psum_addr   (psum_addr),
    .os_capture  (os_capture),
    .busy        (busy),
    .done        (done),
    .error       (error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // expected values for the current cycle
  int  e_inst, e_l0, e_ifr, e_we, e_addr, e_acc, e_relu, e_cap, e_busy, e_done, e_err, e_mode;
  bit  chk_en = 1'b0;
  int  m_mode = 0;
  int  m_err = 0;

  // observed statistics for literal checks
  int cyc = 0;
  int n_load, n_exec, n_ifr, n_rd, n_we, n_acc, n_relu, n_done, n_cap;
  int last_l0, first_drain, done_cyc, done_err, cap_cyc, start_cyc;
  int we_addrs[$];

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0d expected=%0d", nm, cyc, act, expv);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (inst == 2'b01) n_load++;
    if (inst == 2'b10 && l0_rd) n_exec++;
    if (ififo_rd) n_ifr++;
    if (l0_rd || ififo_rd || ofifo_rd) n_rd++;
    if (l0_rd) last_l0 = cyc;
    if (inst == 2'b10 && !l0_rd && first_drain < 0) first_drain = cyc;
    if (psum_we) begin
      n_we++;
      if (acc) n_acc++;
      if (relu) n_relu++;
      we_addrs.push_back(int'(psum_addr));
    end
    if (done) begin
      n_done++;
      done_cyc = cyc;
      done_err = int'(error);
    end
    if (os_capture) begin
      n_cap++;
      cap_cyc = cyc;
    end
    if (chk_en) begin
      chk("inst", int'(inst), e_inst);
      chk("l0_rd", int'(l0_rd), e_l0);
      chk("ififo_rd", int'(ififo_rd), e_ifr);
      chk("ofifo_rd", int'(ofifo_rd), e_we);
      chk("psum_we", int'(psum_we), e_we);
      chk("acc", int'(acc), e_acc);
      chk("relu", int'(relu), e_relu);
      chk("os_capture", int'(os_capture), e_cap);
      chk("mode", int'(mode), e_mode);
      chk("busy", int'(busy), e_busy);
      chk("done", int'(done), e_done);
      chk("error", int'(error), e_err);
      if (e_we != 0) chk("psum_addr", int'(psum_addr), e_addr);
    end
  end

  task automatic clear_stats();
    n_load = 0; n_exec = 0; n_ifr = 0; n_rd = 0; n_we = 0; n_acc = 0; n_relu = 0;
    n_done = 0; n_cap = 0; last_l0 = -1; first_drain = -1; done_cyc = -1;
    done_err = -1; cap_cyc = -1;
    we_addrs.delete();
  endtask

  task automatic exp_clear(input int bsy);
    e_inst = 0; e_l0 = 0; e_ifr = 0; e_we = 0; e_addr = 0; e_acc = 0; e_relu = 0;
    e_cap = 0; e_done = 0; e_busy = bsy; e_mode = m_mode; e_err = m_err;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // cfg inputs and stray starts wander while busy; none of it may matter
  task automatic noise();
    mode_cfg    = 1'($urandom);
    relu_cfg    = 1'($urandom);
    n_vec       = CW'($urandom_range(0, 15));
    n_pass      = 4'($urandom_range(0, 15));
    start       = ($urandom_range(0, 7) == 0);
    ofifo_valid = 1'($urandom);
  endtask

  task automatic idle_cycle();
    exp_clear(0);
    start = 1'b0;
    ofifo_valid = 1'($urandom);
    step();
  endtask

  task automatic run_job(input int md, input int rl, input int nv, input int np,
                         input int vpct, input bit stuck);
    int w;
    int z;
    bit timed_out;
    $display("job mode=%0d relu=%0d n_vec=%0d n_pass=%0d valid_pct=%0d stuck=%0d",
             md, rl, nv, np, vpct, stuck);
    clear_stats();
    exp_clear(0);
    start = 1'b1; mode_cfg = md[0]; relu_cfg = rl[0];
    n_vec = CW'(nv); n_pass = 4'(np); ofifo_valid = 1'($urandom);
    start_cyc = cyc + 1;
    step();
    m_mode = md;
    m_err = 0;
    timed_out = 1'b0;
    if (nv == 0 || np == 0) begin
      m_err = 1;
    end else begin
      for (int p = 0; p < np && !timed_out; p++) begin
        if (md == 0) begin
          repeat (ROW) begin
            exp_clear(1); e_inst = 1; e_l0 = 1; noise(); step();
          end
        end
        repeat (nv) begin
          exp_clear(1); e_inst = 2; e_l0 = 1; e_ifr = md; noise(); step();
        end
        if (md != 0) begin
          repeat (ROW + COL) begin
            exp_clear(1); e_inst = 2; noise(); step();
          end
        end else begin
          w = 0;
          z = 0;
          while (w < nv && z < TMO) begin
            exp_clear(1); e_inst = 2; noise();
            ofifo_valid = stuck ? 1'b0 : ($urandom_range(0, 99) < vpct);
            if (ofifo_valid) begin
              e_we = 1; e_addr = w; e_acc = (p > 0);
              e_relu = (rl != 0) && (p == np - 1);
              w++;
              z = 0;
            end else begin
              z++;
            end
            step();
          end
          if (z == TMO) begin
            m_err = 1;
            timed_out = 1'b1;
          end
        end
        if (!timed_out) begin
          exp_clear(1); e_cap = md; noise(); step();
        end
      end
    end
    exp_clear(1); e_done = 1; noise(); step();
    idle_cycle();
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout cyc=%0d actual=running expected=finished", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    clear_stats();
    #12;
    chk("reset_outputs_zero",
        int'({inst, l0_rd, ififo_rd, ofifo_rd, mode, acc, relu, psum_we, psum_addr,
              os_capture, busy, done, error} != '0), 0);
    #10;
    reset = 1'b1;
    exp_clear(0);
    chk_en = 1'b1;

    run_job(0, 0, 4, 1, 100, 1'b0);
    chk("ws1_load_cycles", n_load, 8);
    chk("ws1_exec_cycles", n_exec, 4);
    chk("ws1_writes", n_we, 4);
    chk("ws1_acc", n_acc, 0);
    chk("ws1_done_pulses", n_done, 1);
    for (int i = 0; i < we_addrs.size(); i++) chk("ws1_addr", we_addrs[i], i);

    run_job(0, 1, 4, 2, 100, 1'b0);
    chk("ws2_load_cycles", n_load, 16);
    chk("ws2_writes", n_we, 8);
    chk("ws2_acc", n_acc, 4);
    chk("ws2_relu", n_relu, 4);
    for (int i = 0; i < we_addrs.size(); i++) chk("ws2_addr", we_addrs[i], i % 4);

    run_job(1, 0, 5, 1, 100, 1'b0);
    chk("os_load_cycles", n_load, 0);
    chk("os_ififo_rd", n_ifr, 5);
    chk("os_exec_cycles", n_exec, 5);
    chk("os_writes", n_we, 0);
    chk("os_capture_pulses", n_cap, 1);
    chk("os_drain_gap", cap_cyc - last_l0 - 1, 16);

    run_job(0, 0, 4, 1, 0, 1'b1);
    chk("wd_done_offset", done_cyc - first_drain, 255);
    chk("wd_error_at_done", done_err, 1);
    chk("wd_writes", n_we, 0);

    run_job(0, 0, 0, 1, 100, 1'b0);
    chk("nv0_done_latency", done_cyc - start_cyc, 1);
    chk("nv0_error_at_done", done_err, 1);
    chk("nv0_reads", n_rd, 0);
    run_job(0, 0, 3, 1, 100, 1'b0);
    chk("recover_error_at_done", done_err, 0);
    chk("recover_writes", n_we, 3);

    run_job(1, 1, 3, 0, 100, 1'b0);
    chk("np0_error_at_done", done_err, 1);
    chk("np0_reads", n_rd, 0);

    for (int j = 0; j < 12; j++) begin
      run_job($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(1, 12),
              $urandom_range(1, 3), $urandom_range(30, 100), 1'b0);
    end

    // asynchronous reset in the middle of EXEC
    chk_en = 1'b0;
    $display("job reset_mid_exec");
    start = 1'b1; mode_cfg = 1'b0; relu_cfg = 1'b1; n_vec = CW'(20); n_pass = 4'd2;
    step();
    start = 1'b0;
    repeat (ROW + 3) step();
    chk("pre_reset_in_exec", int'(inst), 2);
    #2;
    reset = 1'b0;
    #1;
    chk("async_reset_outputs_zero",
        int'({inst, l0_rd, ififo_rd, ofifo_rd, mode, acc, relu, psum_we, psum_addr,
              os_capture, busy, done, error} != '0), 0);
    @(posedge clk);
    #2;
    reset = 1'b1;
    m_mode = 0;
    m_err = 0;
    exp_clear(0);
    chk_en = 1'b1;
    run_job(0, 0, 3, 1, 100, 1'b0);
    chk("post_reset_writes", n_we, 3);
    for (int i = 0; i < we_addrs.size(); i++) chk("post_reset_addr", we_addrs[i], i);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/corelet_seq.md
CORELET_SEQ -- requirements
Module: corelet_seq

Interface
REQ-001 Parameter: row, 8, PE rows and kernel-load length in cycles.
REQ-002 Parameter: col, 8, PE columns, used for OS flush length.
REQ-003 Parameter: cw, 10, width of vector and address counters.
REQ-004 Parameter: tmo, 255, drain watchdog limit in cycles.
REQ-005 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-006 Port: clk  input  1  rising-edge clock.
REQ-007 Port: reset  input  1  asynchronous active-low reset.
REQ-008 Port: start  input  1  job request, sampled only in IDLE.
REQ-009 Port: mode_cfg  input  1  0=weight stationary (WS), 1=output stationary (OS).
REQ-010 Port: relu_cfg  input  1  apply ReLU on final-pass writes.
REQ-011 Port: n_vec  input  cw  input vectors per pass.
REQ-012 Port: n_pass  input  4  accumulation passes.
REQ-013 Port: ofifo_valid  input  1  OFIFO holds a full output row.
REQ-014 Outputs, 1 bit unless noted: inst[1:0] {execute, kernel load}, l0_rd, ififo_rd, ofifo_rd, mode, acc, relu, psum_we, psum_addr[cw-1:0], os_capture, busy, done, error.

Function
REQ-015 States: IDLE, LOAD, EXEC, DRAIN, NEXT, FIN.
REQ-016 IDLE + start=1 SHALL latch mode_cfg, relu_cfg, n_vec and n_pass, then go to LOAD for WS or EXEC for OS on the next cycle.
REQ-017 start=1 with n_vec=0 or n_pass=0 SHALL go to FIN with error=1, and no rd or we is issued.
REQ-018 LOAD SHALL hold inst=01 and l0_rd=1 for exactly row cycles, then go to EXEC.
REQ-019 EXEC SHALL hold inst=10 and l0_rd=1 for exactly n_vec cycles; in OS mode ififo_rd=1 on the same cycles.
REQ-020 inst SHALL stay 10 during DRAIN and be 00 in all other states.
REQ-021 WS DRAIN: ofifo_rd = psum_we = ofifo_valid (combinational); psum_addr starts at 0 each pass and increments after each write; the state exits after n_vec writes.
REQ-022 psum_addr and the read count SHALL hold while ofifo_valid=0.
REQ-023 OS DRAIN SHALL last exactly row+col cycles and then pulse os_capture for 1 cycle; ofifo_rd and psum_we stay 0.
REQ-024 Watchdog: in WS DRAIN, tmo consecutive cycles with ofifo_valid=0 SHALL go to FIN with error=1.
REQ-025 acc SHALL equal psum_we on passes 1 and above, and 0 on pass 0.
REQ-026 relu SHALL equal psum_we AND relu_cfg on the final pass only.
REQ-027 NEXT: if pass < n_pass-1, increment pass and go to LOAD (WS) or EXEC (OS); else go to FIN. NEXT lasts 1 cycle.
REQ-028 FIN SHALL pulse done for 1 cycle, hold error through that cycle, then go to IDLE.
REQ-029 error SHALL clear on the next accepted start.
REQ-030 busy SHALL be 1 in every state except IDLE.
REQ-031 start while busy SHALL be ignored.
REQ-032 Changes to the cfg inputs mid-job SHALL have no effect.
REQ-033 mode SHALL equal the latched mode_cfg.

Reset
REQ-034 reset=0 SHALL, asynchronously in any state: set state to IDLE; clear all counters and latched cfg; drive every output to 0 (inst=00, psum_addr=0, error=0).
REQ-035 After reset release, the first start SHALL be accepted on the first rising edge.

Structure
REQ-036 A shared package SHALL hold the state enumeration and the inst encodings (LOAD=2'b01, EXEC=2'b10, IDLE=2'b00).
REQ-037 Sub-module seq_counter (load, enable, terminal-count flag, parameter width) SHALL be instantiated for the load/exec, address and watchdog counters.
REQ-038 There SHALL be no datapath; all outputs connect one-to-one to corelet control inputs.

Verification
REQ-039 WS, n_vec=4, n_pass=1, ofifo_valid held 1 -> after start: 8 cycles inst=01/l0_rd; 4 cycles inst=10/l0_rd; 4 writes at addr 0..3 with acc=0; done pulses once.
REQ-040 WS, n_pass=2, relu_cfg=1 -> pass 0 writes have acc=0, relu=0; pass 1 writes at addr 0..3 have acc=1, relu=1; LOAD is repeated before pass 1.
REQ-041 OS, n_vec=5 -> no LOAD; 5 cycles of l0_rd=ififo_rd=1; os_capture pulses exactly 16 cycles after EXEC ends; psum_we never asserts.
REQ-042 WS, ofifo_valid stuck at 0 with tmo=255 -> error=1 and done together 255 cycles into DRAIN; returns to IDLE.
REQ-043 n_vec=0 -> done and error in FIN one cycle after start; rd never asserted. Next start with n_vec=3 -> error clears and the job completes normally.
REQ-044 reset=0 asserted mid-EXEC -> all outputs 0 immediately; after release, a new start runs a full job from addr 0.
